// File: rtl/referee_pkg.sv
// rtl/referee_pkg.sv - shared constants, grant type and round-robin search helper
package referee_pkg;

    localparam int NUM_Q         = 4;
    localparam int QIDX_W        = 2;
    localparam int DEF_LINE_SIZE = 12;
    localparam int CLASS_LSB     = 8;
    localparam int CLASS_MSB     = 9;

    // After reset the search starts just past queue 3, so queue 0 wins first
    localparam logic [QIDX_W-1:0] LAST_GRANT_RST = 2'd3;

    typedef struct packed {
        logic              valid;
        logic [QIDX_W-1:0] idx;
    } grant_t;

    // First requesting queue in the order last+1, last+2, last+3, last+4 (mod NUM_Q)
    function automatic grant_t rr_next(input logic [QIDX_W-1:0] last,
                                       input logic [NUM_Q-1:0]  req);
        grant_t            g;
        logic [QIDX_W-1:0] cand;
        g = '0;
        for (int k = 1; k <= NUM_Q; k++) begin
            cand = last + QIDX_W'(k);
            if (!g.valid && req[cand]) begin
                g.valid = 1'b1;
                g.idx   = cand;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - rotating-priority grant with last-winner register
module rr_arbiter
    import referee_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_Q-1:0]  req,
    input  logic              enable,
    output logic [NUM_Q-1:0]  grant,
    output logic              grant_valid,
    output logic [QIDX_W-1:0] grant_idx
);

    logic [QIDX_W-1:0] last_grant;
    grant_t            pick;

    // Grant is purely combinational from req, enable and the last winner; reset kills it at once
    always_comb begin
        pick        = rr_next(last_grant, req);
        grant_valid = pick.valid && enable && reset;
        grant_idx   = pick.idx;
        grant       = '0;
        if (grant_valid) begin
            grant[pick.idx] = 1'b1;
        end
    end

    // Remember the winner so the next search begins after it; no grant leaves it untouched
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= LAST_GRANT_RST;
        end else if (grant_valid) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/rr_referee.sv
// rtl/rr_referee.sv - round-robin drain of four class queues into one egress FIFO
module rr_referee
    import referee_pkg::*;
#(
    parameter int LINE_SIZE = DEF_LINE_SIZE,
    parameter int CNT_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_Q-1:0]           empty,
    input  logic [NUM_Q*LINE_SIZE-1:0] data_in,
    input  logic                       almost_full,
    output logic [NUM_Q-1:0]           pop,
    output logic                       push,
    output logic [LINE_SIZE-1:0]       data_out,
    input  logic                       cnt_req,
    input  logic [QIDX_W-1:0]          cnt_idx,
    output logic                       cnt_valid,
    output logic [CNT_WIDTH-1:0]       cnt_value,
    output logic                       idle
);

    logic                 grant_valid;
    logic [QIDX_W-1:0]    grant_idx;
    logic                 cap_valid;
    logic [QIDX_W-1:0]    cap_idx;
    logic [QIDX_W-1:0]    emit_idx;
    logic [LINE_SIZE-1:0] lanes [NUM_Q];
    logic [LINE_SIZE-1:0] lane_word;
    logic [CNT_WIDTH-1:0] fwd_cnt [NUM_Q];

    rr_arbiter u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (~empty),
        .enable      (~almost_full),
        .grant       (pop),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    for (genvar i = 0; i < NUM_Q; i++) begin : g_lane
        assign lanes[i] = data_in[i*LINE_SIZE +: LINE_SIZE];
    end

    // The source presents a popped word one cycle after the pop, on the lane the capture tag names
    always_comb begin
        lane_word = lanes[cap_idx];
    end

    // Capture stage: remember which lane will carry the word popped this cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_valid <= 1'b0;
            cap_idx   <= '0;
        end else begin
            cap_valid <= grant_valid;
            if (grant_valid) begin
                cap_idx <= grant_idx;
            end
        end
    end

    // Emit stage: register the presented word and raise the egress write for one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            push     <= 1'b0;
            data_out <= '0;
            emit_idx <= '0;
        end else begin
            push <= cap_valid;
            if (cap_valid) begin
                data_out <= lane_word;
                emit_idx <= cap_idx;
            end
        end
    end

    // Counters bump at the close of the push cycle, so a read issued alongside sees the old count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_Q; i++) begin
                fwd_cnt[i] <= '0;
            end
        end else if (push) begin
            fwd_cnt[emit_idx] <= fwd_cnt[emit_idx] + CNT_WIDTH'(1);
        end
    end

    // Debug read port: one-cycle registered response, value held between requests
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_valid <= 1'b0;
            cnt_value <= '0;
        end else begin
            cnt_valid <= cnt_req;
            if (cnt_req) begin
                cnt_value <= fwd_cnt[cnt_idx];
            end
        end
    end

    // Idle when nothing is being popped, nothing is in either stage and every source is drained
    always_comb begin
        idle = !reset || (!grant_valid && !cap_valid && !push && (&empty));
    end

endmodule

// File: tb/tb_rr_referee.sv
// tb/tb_rr_referee.sv - randomized bench for rr_referee against a queue-level reference model
module tb_rr_referee;

    localparam int LS = 12;
    localparam int CW = 5;
    localparam int NQ = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NQ-1:0]   empty;
    logic [NQ*LS-1:0] data_in;
    logic            almost_full;
    logic [NQ-1:0]   pop;
    logic            push;
    logic [LS-1:0]   data_out;
    logic            cnt_req;
    logic [1:0]      cnt_idx;
    logic            cnt_valid;
    logic [CW-1:0]   cnt_value;
    logic            idle;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    rr_referee #(.LINE_SIZE(LS), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .empty       (empty),
        .data_in     (data_in),
        .almost_full (almost_full),
        .pop         (pop),
        .push        (push),
        .data_out    (data_out),
        .cnt_req     (cnt_req),
        .cnt_idx     (cnt_idx),
        .cnt_valid   (cnt_valid),
        .cnt_value   (cnt_value),
        .idle        (idle)
    );

    typedef struct {
        int            due;
        logic [LS-1:0] word;
        int            q;
    } fl_t;

    logic [LS-1:0] src [NQ][$];
    fl_t           inflight [$];
    int            m_last;
    int            m_cnt [NQ];
    logic [LS-1:0] m_data;
    logic          m_cv;
    logic [CW-1:0] m_cval;
    int            push_log [$];
    int            pop_log [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        inflight.delete();
        m_last = 3;
        for (int i = 0; i < NQ; i++) m_cnt[i] = 0;
        m_data = '0;
        m_cv   = 1'b0;
        m_cval = '0;
    endfunction

    function automatic void refresh_empty();
        for (int i = 0; i < NQ; i++) empty[i] = (src[i].size() == 0);
    endfunction

    function automatic logic [LS-1:0] mk_word(input int q);
        logic [1:0] hi;
        logic [7:0] lo;
        hi = 2'($urandom);
        lo = 8'($urandom);
        return {hi, 2'(q), lo};
    endfunction

    task automatic load(input int q, input int n);
        for (int k = 0; k < n; k++) src[q].push_back(mk_word(q));
        refresh_empty();
    endtask

    function automatic int lane_of(input int v);
        for (int i = 0; i < NQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // One clock: check outputs mid-cycle against the model, advance the model, then move the sources
    task automatic step();
        int            g;
        logic [NQ-1:0] e_pop;
        logic          e_push;
        logic          e_idle;
        @(negedge clk);
        if (!reset) model_reset();
        g = -1;
        if (reset && !almost_full) begin
            for (int k = 1; k <= NQ; k++) begin
                int c;
                c = (m_last + k) % NQ;
                if (g < 0 && src[c].size() > 0) g = c;
            end
        end
        e_pop  = (g >= 0) ? NQ'(1 << g) : '0;
        e_push = (inflight.size() > 0) && (inflight[0].due == cyc);
        if (e_push) m_data = inflight[0].word;
        e_idle = !reset || (g < 0 && inflight.size() == 0 && empty == 4'hf);

        chk("pop", pop, e_pop);
        chk("push", push, e_push);
        chk("data_out", data_out, m_data);
        chk("cnt_valid", cnt_valid, m_cv);
        chk("cnt_value", cnt_value, m_cval);
        chk("idle", idle, e_idle);
        if (push) push_log.push_back(int'(data_out[9:8]));
        pop_log.push_back(int'(pop));

        if (reset) begin
            m_cv = cnt_req;
            if (cnt_req) m_cval = CW'(m_cnt[cnt_idx]);
            if (e_push) begin
                m_cnt[inflight[0].q] = (m_cnt[inflight[0].q] + 1) % (1 << CW);
                void'(inflight.pop_front());
            end
            if (g >= 0) begin
                m_last = g;
                inflight.push_back('{cyc + 2, src[g][0], g});
            end
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < NQ; i++) data_in[i*LS +: LS] = LS'($urandom);
        if (g >= 0) data_in[g*LS +: LS] = src[g].pop_front();
        refresh_empty();
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic read_cnt(input int q, input int exp);
        cnt_req = 1'b1;
        cnt_idx = 2'(q);
        step();
        cnt_req = 1'b0;
        chk("rd_valid", cnt_valid, 1'b1);
        chk($sformatf("rd_cnt%0d", q), cnt_value, exp);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int i = 0; i < NQ; i++) src[i].delete();
        refresh_empty();
        steps(2);
        reset = 1'b1;
    endtask

    initial begin
        logic [LS-1:0] first_word;
        int            n_push;
        int            last_lane;

        reset       = 1'b0;
        almost_full = 1'b0;
        cnt_req     = 1'b0;
        cnt_idx     = '0;
        data_in     = '0;
        model_reset();
        for (int q = 0; q < NQ; q++) load(q, 3);

        // Reset held with all queues loaded
        steps(2);
        chk("rst_pop", pop, 4'b0000);
        chk("rst_push", push, 1'b0);
        chk("rst_data", data_out, 12'h000);
        chk("rst_idle", idle, 1'b1);

        // Release: queue 0 first, then strict rotation over 12 words
        first_word = src[0][0];
        push_log.delete();
        reset = 1'b1;
        #1;
        chk("first_pop", pop, 4'b0001);
        steps(2);
        chk("first_push", push, 1'b1);
        chk("first_push_data", data_out, first_word);
        steps(12);
        chk("rot_len", push_log.size(), 12);
        for (int k = 0; k < 12 && k < push_log.size(); k++)
            chk($sformatf("rot_lane%0d", k), push_log[k], k % 4);
        for (int q = 0; q < NQ; q++) read_cnt(q, 3);

        // Single busy queue is granted back to back
        do_reset();
        load(2, 5);
        pop_log.delete();
        push_log.delete();
        steps(8);
        for (int k = 0; k < 5; k++) chk($sformatf("q2_pop%0d", k), pop_log[k], 4);
        chk("q2_pushes", push_log.size(), 5);
        read_cnt(2, 5);

        // Backpressure: two trailing pushes, then silence, then rotation resumes
        do_reset();
        for (int q = 0; q < NQ; q++) load(q, 6);
        pop_log.delete();
        steps(5);
        last_lane = lane_of(pop_log[4]);
        almost_full = 1'b1;
        push_log.delete();
        steps(6);
        n_push = push_log.size();
        chk("af_trailing", n_push, 2);
        almost_full = 1'b0;
        #1;
        chk("af_resume", pop, 4'(1 << ((last_lane + 1) % 4)));
        steps(30);

        // Counter wrap after 33 words, then a read coincident with a push
        do_reset();
        load(1, 33);
        steps(36);
        read_cnt(1, 1);
        load(1, 1);
        steps(2);
        chk("coinc_push", push, 1'b1);
        read_cnt(1, 1);
        read_cnt(1, 2);

        // Reset with two words in flight discards them
        do_reset();
        load(0, 1);
        load(3, 1);
        steps(2);
        reset = 1'b0;
        push_log.delete();
        steps(2);
        reset = 1'b1;
        steps(4);
        chk("rst_inflight_push", push_log.size(), 0);
        for (int q = 0; q < NQ; q++) read_cnt(q, 0);

        // Randomized traffic, backpressure, reads and occasional resets
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            for (int q = 0; q < NQ; q++)
                if (src[q].size() < 6 && $urandom_range(0, 99) < 30) load(q, 1);
            almost_full = ($urandom_range(0, 99) < 20);
            cnt_req     = ($urandom_range(0, 99) < 30);
            cnt_idx     = 2'($urandom);
            reset       = ($urandom_range(0, 199) != 0);
            step();
        end
        reset       = 1'b1;
        almost_full = 1'b0;
        cnt_req     = 1'b0;
        steps(40);
        chk("final_idle", idle, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
